sys_nios2_qsys_0_jtag_ocimem_ctrl: RTL and testbench
====================================================

# sys_nios2_qsys_0_jtag_ocimem_ctrl

On-chip debug-memory controller for the Nios II JTAG debug path. It sits directly downstream of the system-clock half of the JTAG debug module. It consumes that stage's single-cycle `take_action_ocimem_a` / `take_action_ocimem_b` / `take_no_action_ocimem_a` strobes and the `jdo` payload, and performs the requested reads and writes on a 32-bit debug RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` for the JTAG TCK stage to shift out, and it also serves a CPU-side Avalon-MM slave port to the same RAM.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; RAM depth is 2^ADDR_W × 32 bits.

Ports:
- `clk` in 1: single system clock; all logic is synchronous to it.
- `reset_n` in 1: asynchronous, active-low reset.
- `jdo` in 38: JTAG data payload from the sysclk stage.
- `take_action_ocimem_a` in 1: address-load strobe; optionally also a read.
- `take_action_ocimem_b` in 1: write strobe.
- `take_no_action_ocimem_a` in 1: read-and-increment strobe.
- `avs_address` in ADDR_W: CPU word address.
- `avs_read`, `avs_write` in 1: CPU read and write requests.
- `avs_writedata` in 32: CPU write data.
- `avs_byteenable` in 4: CPU byte lanes.
- `avs_readdata` out 32: CPU read data.
- `avs_waitrequest` out 1: Avalon wait.
- `MonAReg` out ADDR_W: JTAG word-address pointer.
- `MonDReg` out 32: last JTAG read data.
- `monitor_ready` out 1: JTAG operation complete.
- `monitor_error` out 1: JTAG strobe overrun or collision.

## Operation
JTAG strobe decode. Strobes are one cycle wide. Each accepted strobe is latched into a pending request.
- `take_action_ocimem_a`:
  - Loads `MonAReg <= jdo[ADDR_W+16:17]` on the same edge.
  - If `jdo[34]=1`, it also queues a read at the new address with no increment.
- `take_action_ocimem_b`: queues a write of `jdo[34:3]` at `MonAReg` with all byte lanes; `MonAReg` increments afterwards.
- `take_no_action_ocimem_a`: queues a read at `MonAReg`; `MonAReg` increments afterwards.
- `MonAReg` increments modulo 2^ADDR_W, so the maximum address wraps to 0.
- Accepting any strobe clears `monitor_ready`.
- More than one strobe in the same cycle:
  - Priority is a > b > no_action.
  - Lower-priority strobes are dropped and `monitor_error` is set.
- A strobe arriving while a request is pending, or while the FSM is in any J_* state, is dropped and sets `monitor_error`.
- An accepted `take_action_ocimem_a` clears `monitor_error`. If an error-set condition occurs in the same cycle, set wins.

FSM states: IDLE, J_RD, J_RDD, J_WR, C_RD, C_RDD, C_WR.
- IDLE:
  - A pending JTAG read goes to J_RD; a pending JTAG write goes to J_WR.
  - Otherwise `avs_read` goes to C_RD, and `avs_write` goes to C_WR.
  - If `avs_read` and `avs_write` are asserted together, read wins.
  - JTAG pending always wins over CPU.
  - The pending flag clears on leaving IDLE.
- J_RD: present `MonAReg` to the RAM, then go to J_RDD.
- J_RDD: `MonDReg <= q`, `monitor_ready <= 1`, apply the increment if queued, then go to IDLE.
- J_WR: write the RAM, `monitor_ready <= 1`, `MonAReg++`, then go to IDLE.
- C_RD: present `avs_address`, then go to C_RDD.
- C_RDD: `avs_readdata = q`, `avs_waitrequest = 0`, then go to IDLE.
- C_WR: write `avs_writedata` under `avs_byteenable`, `avs_waitrequest = 0`, then go to IDLE.

Other rules:
- `avs_waitrequest` is 1 in every state except C_RDD and C_WR.
- The RAM has registered output with 1-cycle read latency and is single-ported.

## Timing
- Reset values:
  - State IDLE; pending cleared.
  - `MonAReg=0`, `MonDReg=0`.
  - `monitor_ready=0`, `monitor_error=0`.
  - `avs_readdata=0`, `avs_waitrequest=1`.
  - RAM contents are not reset.
- JTAG read: strobe sampled at edge E0; J_RD after E1; `MonDReg` and `monitor_ready` valid after E3.
- JTAG write: J_WR after E1; RAM and `MonAReg` updated and `monitor_ready=1` after E2.
- CPU read: request sampled in IDLE at E0; `avs_waitrequest` is low for one cycle after E1. Total 3 cycles, 2 of them waited.
- CPU write: request sampled in IDLE at E0; `avs_waitrequest` is low in the cycle after E0; the RAM is written at E1.
- A CPU request held during JTAG service waits, with `avs_waitrequest=1`, until IDLE.
- A strobe arriving while a CPU access is in progress is accepted and latched; it is serviced at the next IDLE.
- Reset asserted mid-operation aborts immediately:
  - Any in-flight write not yet clocked is lost.
  - The pending request is discarded.

## Test plan
- Reset: assert `reset_n=0` mid-J_RD → all outputs take their reset values; after release the FSM is in IDLE and `avs_waitrequest=1`.
- Load and write burst: `take_action_ocimem_a` with `jdo[24:17]=8'h10`, `jdo[34]=0`; then three b strobes spaced 4 cycles with data 32'h11111111, 32'h22222222, 32'h33333333 → `MonAReg=8'h13`; CPU reads of 0x10..0x12 return the three words.
- Byte lanes plus JTAG read: CPU writes 0 to 0x20, then writes 32'hDEADBEEF with be 4'b0011; then a strobe with `jdo[24:17]=8'h20`, `jdo[34]=1` → `MonDReg=32'h0000BEEF` and `monitor_ready=1` three cycles after the strobe; `MonAReg` stays at 8'h20.
- Wrap: load `MonAReg=8'hFF`, then `take_no_action_ocimem_a` → read of 0xFF, and `MonAReg=8'h00`.
- Overrun: two b strobes on consecutive cycles → the first write completes, the second is dropped and `monitor_error=1`; the next `take_action_ocimem_a` clears it.
- Contention: JTAG write pending while `avs_read` is asserted in the same IDLE cycle → JTAG is serviced first, `avs_waitrequest` is held high, and the CPU read then returns the newly written data.

Source files
------------

// File: rtl/sys_nios2_qsys_0_jtag_ocimem_ctrl.sv
// Nios II JTAG debug-memory controller.
// Serves JTAG strobes and an Avalon-MM slave on one RAM.
module sys_nios2_qsys_0_jtag_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {
    IDLE, J_RD, J_RDD, J_WR, C_RD, C_RDD, C_WR
  } state_t;

  state_t state;

  logic        pend;
  logic        pend_wr;
  logic        pend_inc;
  logic [31:0] wr_data;

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] q;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wd;

  logic a;
  logic b;
  logic na;
  logic win_a;
  logic win_b;
  logic win_na;
  logic any;
  logic multi;
  logic j_busy;
  logic acc;
  logic set_err;
  logic unused;

  assign a  = take_action_ocimem_a;
  assign b  = take_action_ocimem_b;
  assign na = take_no_action_ocimem_a;

  assign win_a  = a;
  assign win_b  = b & ~a;
  assign win_na = na & ~a & ~b;

  assign any    = a | b | na;
  assign multi  = (a & b) | (a & na) | (b & na);
  assign j_busy = (state == J_RD)
                | (state == J_RDD)
                | (state == J_WR);
  assign acc     = any & ~pend & ~j_busy;
  assign set_err = multi | (any & ~acc);

  assign unused = ^{jdo[37:35], jdo[2:0]};

  assign avs_waitrequest = ~((state == C_RDD)
                           | (state == C_WR));
  assign avs_readdata = (state == C_RDD) ? q : '0;

  // RAM port steering from the current FSM state
  always_comb begin
    ram_addr = MonAReg;
    ram_we   = 1'b0;
    ram_be   = 4'hF;
    ram_wd   = wr_data;
    unique case (state)
      J_WR: ram_we = 1'b1;
      C_RD: ram_addr = avs_address;
      C_WR: begin
        ram_addr = avs_address;
        ram_we   = 1'b1;
        ram_be   = avs_byteenable;
        ram_wd   = avs_writedata;
      end
      default: ;
    endcase
  end

  // Single-port RAM, byte-lane writes, registered read
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && ram_be[i]) begin
        mem[ram_addr][i*8 +: 8] <= ram_wd[i*8 +: 8];
      end
    end
    q <= mem[ram_addr];
  end

  // Strobe capture, error tracking and access FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pend          <= 1'b0;
      pend_wr       <= 1'b0;
      pend_inc      <= 1'b0;
      wr_data       <= '0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (acc) begin
        monitor_ready <= 1'b0;
        unique case (1'b1)
          win_a: begin
            MonAReg  <= jdo[ADDR_W+16:17];
            pend     <= jdo[34];
            pend_wr  <= 1'b0;
            pend_inc <= 1'b0;
          end
          win_b: begin
            pend     <= 1'b1;
            pend_wr  <= 1'b1;
            pend_inc <= 1'b0;
            wr_data  <= jdo[34:3];
          end
          win_na: begin
            pend     <= 1'b1;
            pend_wr  <= 1'b0;
            pend_inc <= 1'b1;
          end
          default: ;
        endcase
      end

      if (set_err) begin
        monitor_error <= 1'b1;
      end else if (acc && win_a) begin
        monitor_error <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (pend) begin
            pend  <= 1'b0;
            state <= pend_wr ? J_WR : J_RD;
          end else if (avs_read) begin
            state <= C_RD;
          end else if (avs_write) begin
            state <= C_WR;
          end
        end
        J_RD: state <= J_RDD;
        J_RDD: begin
          MonDReg       <= q;
          monitor_ready <= 1'b1;
          if (pend_inc) begin
            MonAReg <= MonAReg + ADDR_W'(1);
          end
          state <= IDLE;
        end
        J_WR: begin
          monitor_ready <= 1'b1;
          MonAReg       <= MonAReg + ADDR_W'(1);
          state         <= IDLE;
        end
        C_RD:  state <= C_RDD;
        C_RDD: state <= IDLE;
        C_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_nios2_qsys_0_jtag_ocimem_ctrl.sv
// Bench for the JTAG debug-memory controller.
// Transaction model with scheduled register updates.
module tb_sys_nios2_qsys_0_jtag_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  sys_nios2_qsys_0_jtag_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonAReg                 (MonAReg),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          s_mar;
    logic [7:0]  mar;
    bit          s_mdr;
    logic [31:0] mdr;
    bit          s_rdy;
    logic        rdy;
    bit          s_err;
    logic        err;
  } ev_t;

  ev_t         sched[$];
  logic [31:0] m_mem [256];
  logic [7:0]  m_mar;
  logic [7:0]  m_cur;
  logic [31:0] m_mdr;
  logic        m_rdy;
  logic        m_err;
  int          m_busy;
  bit          chk_en = 0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ev_t ev(input int at);
    ev_t e;
    e.at = at;
    e.s_mar = 0; e.mar = '0;
    e.s_mdr = 0; e.mdr = '0;
    e.s_rdy = 0; e.rdy = 1'b0;
    e.s_err = 0; e.err = 1'b0;
    return e;
  endfunction

  task automatic m_reset();
    sched.delete();
    m_mar  = '0;
    m_cur  = '0;
    m_mdr  = '0;
    m_rdy  = 1'b0;
    m_err  = 1'b0;
    m_busy = 0;
  endtask

  // Apply the strobe rules to the model: priority, drop, latency.
  task automatic m_strobe(input logic a, input logic b, input logic na);
    int  e;
    bit  multi;
    ev_t x;
    ev_t y;
    e = cyc + 1;
    multi = (int'(a) + int'(b) + int'(na)) > 1;
    x = ev(e);
    if (e < m_busy) begin
      x.s_err = 1; x.err = 1'b1;
      sched.push_back(x);
      return;
    end
    x.s_rdy = 1; x.rdy = 1'b0;
    if (multi) begin
      x.s_err = 1; x.err = 1'b1;
    end
    if (a) begin
      m_cur = jdo[24:17];
      x.s_mar = 1; x.mar = m_cur;
      if (!multi) begin
        x.s_err = 1; x.err = 1'b0;
      end
      sched.push_back(x);
      if (jdo[34]) begin
        y = ev(e + 3);
        y.s_mdr = 1; y.mdr = m_mem[m_cur];
        y.s_rdy = 1; y.rdy = 1'b1;
        sched.push_back(y);
        m_busy = e + 4;
      end
    end else if (b) begin
      m_mem[m_cur] = jdo[34:3];
      m_cur = m_cur + 8'd1;
      sched.push_back(x);
      y = ev(e + 2);
      y.s_mar = 1; y.mar = m_cur;
      y.s_rdy = 1; y.rdy = 1'b1;
      sched.push_back(y);
      m_busy = e + 3;
    end else begin
      y = ev(e + 3);
      y.s_mdr = 1; y.mdr = m_mem[m_cur];
      m_cur = m_cur + 8'd1;
      y.s_mar = 1; y.mar = m_cur;
      y.s_rdy = 1; y.rdy = 1'b1;
      sched.push_back(x);
      sched.push_back(y);
      m_busy = e + 4;
    end
  endtask

  // Compare process: retire due model events, check DUT every cycle.
  initial begin
    ev_t e;
    int  n;
    forever begin
      @(negedge clk);
      n = sched.size();
      for (int i = 0; i < n; i++) begin
        e = sched.pop_front();
        if (e.at <= cyc) begin
          if (e.s_mar) m_mar = e.mar;
          if (e.s_mdr) m_mdr = e.mdr;
          if (e.s_rdy) m_rdy = e.rdy;
          if (e.s_err) m_err = e.err;
        end else begin
          sched.push_back(e);
        end
      end
      if (chk_en) begin
        check("cmp_MonAReg", {24'h0, MonAReg}, {24'h0, m_mar});
        check("cmp_MonDReg", MonDReg, m_mdr);
        check("cmp_ready", {31'h0, monitor_ready}, {31'h0, m_rdy});
        check("cmp_error", {31'h0, monitor_error}, {31'h0, m_err});
        if (!reset_n) begin
          check("cmp_wait_rst", {31'h0, avs_waitrequest}, 32'h1);
        end
        if (reset_n && avs_read && !avs_waitrequest) begin
          check("cmp_readdata", avs_readdata, m_mem[avs_address]);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic a, input logic b, input logic na,
                        input logic [7:0] addr, input logic rd,
                        input logic [31:0] data);
    jdo = '0;
    if (b) jdo[34:3] = data;
    if (a) begin
      jdo[24:17] = addr;
      jdo[34]    = rd;
    end
    m_strobe(a, b, na);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = na;
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] addr,
                          output logic [31:0] d,
                          output int waits);
    bit done;
    done = 0;
    waits = 0;
    d = 'x;
    avs_address = addr;
    avs_read = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        d = avs_readdata;
        done = 1;
      end else begin
        waits++;
      end
    end
    check("cpu_read_done", {31'h0, done}, 32'h1);
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] addr,
                           input logic [31:0] d,
                           input logic [3:0] be,
                           output int waits);
    bit done;
    done = 0;
    waits = 0;
    avs_address = addr;
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        done = 1;
        for (int k = 0; k < 4; k++) begin
          if (be[k]) m_mem[addr][k*8 +: 8] = d[k*8 +: 8];
        end
      end else begin
        waits++;
      end
    end
    check("cpu_write_done", {31'h0, done}, 32'h1);
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          w;
    logic [31:0] burst [3];
    burst[0] = 32'h11111111;
    burst[1] = 32'h22222222;
    burst[2] = 32'h33333333;

    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = '0;
    m_reset();
    tick(3);
    chk_en = 1;
    reset_n = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_wait", {31'h0, avs_waitrequest}, 32'h1);
    check("rst_rdata", avs_readdata, 32'h0);
    check("rst_mar", {24'h0, MonAReg}, 32'h0);
    check("rst_ready", {31'h0, monitor_ready}, 32'h0);
    tick();

    cpu_write(8'h40, 32'h12345678, 4'hF, w);
    check("cpu_wr_waits", w, 1);
    cpu_read(8'h40, d, w);
    check("cpu_rd_waits", w, 2);
    check("cpu_rd_data", d, 32'h12345678);

    strobe(1, 0, 0, 8'h10, 1'b0, 32'h0);
    tick(3);
    for (int i = 0; i < 3; i++) begin
      strobe(0, 1, 0, 8'h00, 1'b0, burst[i]);
      tick(3);
    end
    check("burst_mar", {24'h0, MonAReg}, 32'h13);
    check("burst_ready", {31'h0, monitor_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cpu_read(8'h10 + 8'(i), d, w);
      check("burst_rd", d, burst[i]);
    end

    cpu_write(8'h20, 32'h0, 4'hF, w);
    cpu_write(8'h20, 32'hDEADBEEF, 4'b0011, w);
    strobe(1, 0, 0, 8'h20, 1'b1, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("jrd_ready_e2", {31'h0, monitor_ready}, 32'h0);
    @(negedge clk);
    check("jrd_ready_e3", {31'h0, monitor_ready}, 32'h1);
    check("jrd_mdr", MonDReg, 32'h0000BEEF);
    check("jrd_mar", {24'h0, MonAReg}, 32'h20);
    tick(2);

    cpu_write(8'hFF, 32'hA5A50FF0, 4'hF, w);
    strobe(1, 0, 0, 8'hFF, 1'b0, 32'h0);
    tick(2);
    strobe(0, 0, 1, 8'h00, 1'b0, 32'h0);
    tick(5);
    check("wrap_mdr", MonDReg, 32'hA5A50FF0);
    check("wrap_mar", {24'h0, MonAReg}, 32'h00);

    cpu_write(8'h51, 32'h0, 4'hF, w);
    strobe(1, 0, 0, 8'h50, 1'b0, 32'h0);
    tick(2);
    strobe(0, 1, 0, 8'h00, 1'b0, 32'hCAFE0001);
    strobe(0, 1, 0, 8'h00, 1'b0, 32'hCAFE0002);
    tick(4);
    check("ovr_err", {31'h0, monitor_error}, 32'h1);
    check("ovr_mar", {24'h0, MonAReg}, 32'h51);
    cpu_read(8'h50, d, w);
    check("ovr_rd0", d, 32'hCAFE0001);
    cpu_read(8'h51, d, w);
    check("ovr_rd1", d, 32'h0);
    strobe(1, 0, 0, 8'h60, 1'b0, 32'h0);
    tick(2);
    check("ovr_clr", {31'h0, monitor_error}, 32'h0);

    cpu_write(8'h70, 32'h77777777, 4'hF, w);
    strobe(1, 1, 0, 8'h70, 1'b0, 32'h12121212);
    tick(3);
    check("multi_mar", {24'h0, MonAReg}, 32'h70);
    check("multi_err", {31'h0, monitor_error}, 32'h1);
    cpu_read(8'h70, d, w);
    check("multi_rd", d, 32'h77777777);

    cpu_write(8'h30, 32'h0, 4'hF, w);
    strobe(1, 0, 0, 8'h30, 1'b0, 32'h0);
    tick(2);
    strobe(0, 1, 0, 8'h00, 1'b0, 32'h0BADF00D);
    cpu_read(8'h30, d, w);
    check("cont_waits", w, 4);
    check("cont_rd", d, 32'h0BADF00D);
    tick(2);

    strobe(1, 0, 0, 8'h20, 1'b1, 32'h0);
    tick(1);
    reset_n = 1'b0;
    m_reset();
    @(negedge clk);
    check("mid_rst_wait", {31'h0, avs_waitrequest}, 32'h1);
    check("mid_rst_mdr", MonDReg, 32'h0);
    check("mid_rst_mar", {24'h0, MonAReg}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(6);
    check("post_rst_ready", {31'h0, monitor_ready}, 32'h0);
    check("post_rst_wait", {31'h0, avs_waitrequest}, 32'h1);
    cpu_read(8'h20, d, w);
    check("post_rst_waits", w, 2);
    check("post_rst_rd", d, 32'h0000BEEF);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
